// File: rtl/acc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// acc_ctrl_pkg
//   Shared definitions for the accumulator controller: the write-side FSM
//   state encoding and the default counter width used by the controller and
//   its drain sub-block.
// ---------------------------------------------------------------------------
package acc_ctrl_pkg;

   // Default width of k_len, n_res and the internal job counters.
   localparam int ACC_CNT_WIDTH = 8;

   // Write-side FSM states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCUM  = 2'd1,
      ST_COMMIT = 2'd2,
      ST_FINISH = 2'd3
   } acc_state_t;

endpackage : acc_ctrl_pkg

// File: rtl/acc_drain.sv
// ---------------------------------------------------------------------------
// acc_drain
//   Read side of the accumulator controller. Pops finished sums out of the
//   AccumulatorUnit FIFO into a single output register and presents them on a
//   valid/ready stream. Also counts delivered results for the current job.
//
// Ports:
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   clear          one-cycle pulse at job launch; zeroes the delivered count
//   acc_empty      AccumulatorUnit FIFO empty flag
//   acc_d_out      AccumulatorUnit FIFO read data (valid the cycle after a pop)
//   acc_r_enable   pop request to the AccumulatorUnit
//   out_valid      output register holds a result
//   out_data       result value
//   out_ready      downstream accepts the result
//   delivered      number of results handed off in the current job
//
// Handshake: a result transfers on every rising edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, and out_data
// stays unchanged, until that transfer happens; out_valid never depends on
// out_ready combinationally.
// ---------------------------------------------------------------------------
module acc_drain
   import acc_ctrl_pkg::*;
#(
   parameter int WORD_WIDTH = 8,
   parameter int CNT_WIDTH  = ACC_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  acc_empty,
   input  logic [WORD_WIDTH-1:0] acc_d_out,
   output logic                  acc_r_enable,
   output logic                  out_valid,
   output logic [WORD_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [CNT_WIDTH-1:0]  delivered
);

   logic                  pop_pending_q, pop_pending_d;
   logic                  out_valid_q,   out_valid_d;
   logic [WORD_WIDTH-1:0] out_data_q,    out_data_d;
   logic [CNT_WIDTH-1:0]  delivered_q,   delivered_d;
   logic                  pop;
   logic                  handshake;

   // Only one pop may be in flight: the popped word lands on acc_d_out a
   // cycle later, and the output register must be free (or emptying this
   // cycle) to receive it. This caps throughput at one result per two cycles.
   assign pop       = !acc_empty && !pop_pending_q && (!out_valid_q || out_ready);
   assign handshake = out_valid_q && out_ready;

   always_comb begin
      pop_pending_d = pop;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      delivered_d   = delivered_q;

      if (pop_pending_q) begin
         out_data_d  = acc_d_out;
         out_valid_d = 1'b1;
      end else if (handshake) begin
         out_valid_d = 1'b0;
      end

      if (clear) begin
         delivered_d = '0;
      end else if (handshake) begin
         delivered_d = delivered_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pop_pending_q <= 1'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         delivered_q   <= '0;
      end else begin
         pop_pending_q <= pop_pending_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         delivered_q   <= delivered_d;
      end
   end

   assign acc_r_enable = pop;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign delivered    = delivered_q;

endmodule : acc_drain

// File: rtl/accumulator_controller.sv
// ---------------------------------------------------------------------------
// accumulator_controller
//   Sequences one AccumulatorUnit for a job of n_res results, each the sum of
//   k_len partial sums. The write FSM streams partial sums into the unit's
//   accumulation register and commits each finished sum into its FIFO; the
//   acc_drain block independently pops the FIFO onto a valid/ready stream.
//
// Ports:
//   clk, reset_n          clock (rising edge), asynchronous active-low reset
//   start, k_len, n_res   job launch (sampled in IDLE only); k_len 0 acts as 1
//   psum_valid/data/ready partial-sum input stream
//   out_valid/data/ready  result output stream
//   busy                  job in progress
//   done                  one-cycle pulse when every result has been delivered
//   acc_a/w/r_enable      accumulate / push / pop strobes to the unit
//   acc_d_in              value to accumulate (psum_data pass-through)
//   acc_full, acc_empty   FIFO status from the unit
//   acc_d_out             FIFO read data from the unit
//
// Handshakes: a partial sum transfers on a rising edge with psum_valid and
// psum_ready both 1; a result transfers on a rising edge with out_valid and
// out_ready both 1. Neither ready depends on its own valid.
// ---------------------------------------------------------------------------
module accumulator_controller
   import acc_ctrl_pkg::*;
#(
   parameter int WORD_WIDTH = 8,
   parameter int FIFO_CAP   = 16,
   parameter int PTR_WIDTH  = 4,
   parameter int CNT_WIDTH  = ACC_CNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  k_len,
   input  logic [CNT_WIDTH-1:0]  n_res,
   input  logic                  psum_valid,
   input  logic [WORD_WIDTH-1:0] psum_data,
   output logic                  psum_ready,
   output logic                  out_valid,
   output logic [WORD_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done,
   output logic                  acc_a_enable,
   output logic                  acc_w_enable,
   output logic                  acc_r_enable,
   output logic [WORD_WIDTH-1:0] acc_d_in,
   input  logic                  acc_full,
   input  logic                  acc_empty,
   input  logic [WORD_WIDTH-1:0] acc_d_out
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   acc_state_t           state_q,   state_d;
   logic [CNT_WIDTH-1:0] k_eff_q,   k_eff_d;
   logic [CNT_WIDTH-1:0] n_res_q,   n_res_d;
   logic [CNT_WIDTH-1:0] k_cnt_q,   k_cnt_d;
   logic [CNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;

   logic [CNT_WIDTH-1:0] k_cnt_inc;
   logic [CNT_WIDTH-1:0] res_cnt_inc;
   logic                 job_start;
   logic [CNT_WIDTH-1:0] delivered;

   assign k_cnt_inc   = k_cnt_q + 1'b1;
   assign res_cnt_inc = res_cnt_q + 1'b1;

   // -------------------------------------------------------------------------
   // Write-side FSM: next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      k_eff_d      = k_eff_q;
      n_res_d      = n_res_q;
      k_cnt_d      = k_cnt_q;
      res_cnt_d    = res_cnt_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      job_start    = 1'b0;
      psum_ready   = 1'b0;
      acc_a_enable = 1'b0;
      acc_w_enable = 1'b0;
      acc_d_in     = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               job_start = 1'b1;
               k_eff_d   = (k_len == '0) ? CNT_ONE : k_len;
               n_res_d   = n_res;
               k_cnt_d   = '0;
               res_cnt_d = '0;
               busy_d    = 1'b1;
               state_d   = (n_res == '0) ? ST_FINISH : ST_ACCUM;
            end
         end

         ST_ACCUM: begin
            psum_ready = 1'b1;
            if (psum_valid) begin
               acc_a_enable = 1'b1;
               acc_d_in     = psum_data;
               k_cnt_d      = k_cnt_inc;
               if (k_cnt_inc == k_eff_q) begin
                  state_d = ST_COMMIT;
               end
            end
         end

         ST_COMMIT: begin
            // A full FIFO holds us here, which in turn holds psum_ready low:
            // this is the only path by which output backpressure reaches the
            // partial-sum input.
            if (!acc_full) begin
               acc_w_enable = 1'b1;
               res_cnt_d    = res_cnt_inc;
               k_cnt_d      = '0;
               state_d      = (res_cnt_inc == n_res_q) ? ST_FINISH : ST_ACCUM;
            end
         end

         ST_FINISH: begin
            if (delivered == n_res_q) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         k_eff_q   <= '0;
         n_res_q   <= '0;
         k_cnt_q   <= '0;
         res_cnt_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_eff_q   <= k_eff_d;
         n_res_q   <= n_res_d;
         k_cnt_q   <= k_cnt_d;
         res_cnt_q <= res_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   // -------------------------------------------------------------------------
   // Read side
   // -------------------------------------------------------------------------
   acc_drain #(
      .WORD_WIDTH (WORD_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH)
   ) u_drain (
      .clk          (clk),
      .reset_n      (reset_n),
      .clear        (job_start),
      .acc_empty    (acc_empty),
      .acc_d_out    (acc_d_out),
      .acc_r_enable (acc_r_enable),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .delivered    (delivered)
   );

   // -------------------------------------------------------------------------
   // Committed-but-undelivered results can never exceed the FIFO plus the
   // output register, and the unit's pointers must be wide enough for its
   // depth.
   // -------------------------------------------------------------------------
   localparam logic [CNT_WIDTH:0] MAX_IN_FLIGHT = (CNT_WIDTH+1)'(FIFO_CAP + 1);
   localparam bit                 PTR_FITS      = (FIFO_CAP <= (1 << PTR_WIDTH));

   logic [CNT_WIDTH-1:0] in_flight;
   assign in_flight = res_cnt_q - delivered;

   a_in_flight_bound : assert property (
      @(posedge clk) disable iff (!reset_n)
      busy_q |-> (({1'b0, in_flight} <= MAX_IN_FLIGHT) && PTR_FITS)
   );

endmodule : accumulator_controller

// File: tb/tb_accumulator_controller.sv
// ---------------------------------------------------------------------------
// tb_accumulator_controller
//   Directed bench for accumulator_controller. Contains a behavioural model of
//   the AccumulatorUnit (accumulation register + 16-deep FIFO with registered
//   read data), a result scoreboard fed with hand-computed sums, and directed
//   jobs covering the basic sum, ordering, wrap, FIFO-full stall, random
//   gaps, k_len=0, n_res=0 and reset in the middle of a job.
// ---------------------------------------------------------------------------
module tb_accumulator_controller;

   localparam int WW = 8;
   localparam int CW = 8;
   localparam int FC = 16;
   localparam int PW = 4;

   // ---------------- clock / reset ----------------
   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          start      = 1'b0;
   logic [CW-1:0] k_len      = '0;
   logic [CW-1:0] n_res      = '0;
   logic          psum_valid = 1'b0;
   logic [WW-1:0] psum_data  = '0;
   logic          psum_ready;
   logic          out_valid;
   logic [WW-1:0] out_data;
   logic          out_ready  = 1'b0;
   logic          busy;
   logic          done;
   logic          acc_a_enable;
   logic          acc_w_enable;
   logic          acc_r_enable;
   logic [WW-1:0] acc_d_in;
   logic          acc_full;
   logic          acc_empty;
   logic [WW-1:0] acc_d_out;

   accumulator_controller #(
      .WORD_WIDTH (WW),
      .FIFO_CAP   (FC),
      .PTR_WIDTH  (PW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .k_len        (k_len),
      .n_res        (n_res),
      .psum_valid   (psum_valid),
      .psum_data    (psum_data),
      .psum_ready   (psum_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .busy         (busy),
      .done         (done),
      .acc_a_enable (acc_a_enable),
      .acc_w_enable (acc_w_enable),
      .acc_r_enable (acc_r_enable),
      .acc_d_in     (acc_d_in),
      .acc_full     (acc_full),
      .acc_empty    (acc_empty),
      .acc_d_out    (acc_d_out)
   );

   // ---------------- AccumulatorUnit model ----------------
   logic [WW-1:0] m_acc;
   logic [WW-1:0] m_dout;
   logic [WW-1:0] m_mem [FC];
   logic [PW-1:0] m_wp;
   logic [PW-1:0] m_rp;
   logic [PW:0]   m_cnt;
   logic          m_push;
   logic          m_pop;

   assign acc_full  = (m_cnt == (PW+1)'(FC));
   assign acc_empty = (m_cnt == '0);
   assign acc_d_out = m_dout;
   assign m_push    = acc_w_enable && !acc_full;
   assign m_pop     = acc_r_enable && !acc_empty;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_acc  <= '0;
         m_dout <= '0;
         m_wp   <= '0;
         m_rp   <= '0;
         m_cnt  <= '0;
      end else begin
         if (acc_a_enable) m_acc <= m_acc + acc_d_in;
         if (m_push) begin
            m_mem[m_wp] <= m_acc;
            m_acc       <= '0;
            m_wp        <= m_wp + 1'b1;
         end
         if (m_pop) begin
            m_dout <= m_mem[m_rp];
            m_rp   <= m_rp + 1'b1;
         end
         m_cnt <= m_cnt + (PW+1)'(m_push) - (PW+1)'(m_pop);
      end
   end

   // ---------------- scoreboard and checking ----------------
   logic [WW-1:0] exp_q[$];
   logic [WW-1:0] psum_q[$];
   int checks   = 0;
   int failures = 0;
   int a_cnt = 0, w_cnt = 0, r_cnt = 0, hs_cnt = 0, done_cnt = 0;
   int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
   logic          hold_prev = 1'b0;
   logic [WW-1:0] hold_data = '0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Monitor: samples mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         if (acc_a_enable) a_cnt++;
         if (acc_w_enable) w_cnt++;
         if (acc_r_enable) r_cnt++;
         if (done)         done_cnt++;
         if (acc_w_enable) check("aw_exclusive", acc_a_enable, 0);
         if (hold_prev) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_data);
         end
         if (out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) check("unexpected_result", out_data, 32'hFFFF_FFFF);
            else                   check("result", out_data, exp_q.pop_front());
         end
         hold_prev = out_valid && !out_ready;
         hold_data = out_data;
      end else begin
         hold_prev = 1'b0;
      end
   end

   // out_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(99) < 60);
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      a_cnt = 0; w_cnt = 0; r_cnt = 0; hs_cnt = 0; done_cnt = 0;
   endtask

   task automatic start_job(input int k, input int n);
      k_len = CW'(k);
      n_res = CW'(n);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic drive_psums(input int gap_pct);
      int budget = 3000;
      while (psum_q.size() > 0 && budget > 0) begin
         psum_valid = ($urandom_range(99) >= gap_pct);
         psum_data  = psum_q[0];
         @(negedge clk);
         if (psum_valid && psum_ready) void'(psum_q.pop_front());
         @(posedge clk);
         #1;
         budget--;
      end
      psum_valid = 1'b0;
      check("psum_drained", psum_q.size(), 0);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_seen", (done_cnt != 0), 1);
      cycles(3);
      check("done_width", done_cnt, 1);
      check("busy_low", busy, 0);
      check("results_left", exp_q.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_psum_ready"}, psum_ready, 0);
      check({tag, "_out_valid"},  out_valid, 0);
      check({tag, "_out_data"},   out_data, 0);
      check({tag, "_busy"},       busy, 0);
      check({tag, "_done"},       done, 0);
      check({tag, "_acc_en"},     {acc_a_enable, acc_w_enable, acc_r_enable}, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- directed tests ----------------
   initial begin
      // Reset state
      cycles(3);
      check_idle_outputs("reset");
      reset_n = 1'b1;
      cycles(2);

      // 1: k=3, n=1, psums 4,3,5 -> 12
      clear_stats();
      exp_q.push_back(8'd12);
      start_job(3, 1);
      check("t1_busy", busy, 1);
      psum_q = '{8'd4, 8'd3, 8'd5};
      drive_psums(0);
      wait_done(200);
      check("t1_a_cnt", a_cnt, 3);
      check("t1_w_cnt", w_cnt, 1);
      check("t1_hs", hs_cnt, 1);

      // 2: k=2, n=4, psums 1..8 -> 3,7,11,15
      clear_stats();
      exp_q = '{8'd3, 8'd7, 8'd11, 8'd15};
      start_job(2, 4);
      for (int i = 1; i <= 8; i++) psum_q.push_back(WW'(i));
      drive_psums(0);
      wait_done(200);
      check("t2_hs", hs_cnt, 4);
      check("t2_w_cnt", w_cnt, 4);

      // 3: 200 + 100 wraps to 44
      clear_stats();
      exp_q.push_back(8'd44);
      start_job(2, 1);
      psum_q = '{8'd200, 8'd100};
      drive_psums(0);
      wait_done(200);
      check("t3_hs", hs_cnt, 1);

      // 4: k=1, n=18 with out_ready low: 17 buffered, the 18th stalls COMMIT
      clear_stats();
      ready_mode = 1;
      cycles(1);
      start_job(1, 18);
      for (int i = 1; i <= 18; i++) begin
         psum_q.push_back(WW'(i));
         exp_q.push_back(WW'(i));
      end
      drive_psums(0);
      cycles(6);
      check("t4_acc_full", acc_full, 1);
      check("t4_w_stall", acc_w_enable, 0);
      check("t4_psum_ready", psum_ready, 0);
      check("t4_a_cnt", a_cnt, 18);
      check("t4_w_cnt", w_cnt, 17);
      check("t4_out_valid", out_valid, 1);
      check("t4_out_data", out_data, 1);
      check("t4_hs_none", hs_cnt, 0);
      check("t4_busy", busy, 1);
      ready_mode = 0;
      wait_done(400);
      check("t4_hs", hs_cnt, 18);
      check("t4_w_total", w_cnt, 18);

      // 5: k=4, n=5, random gaps on both sides, stray start mid-job
      clear_stats();
      ready_mode = 2;
      exp_q = '{8'd10, 8'd26, 8'd42, 8'd58, 8'd74};
      start_job(4, 5);
      for (int i = 1; i <= 20; i++) psum_q.push_back(WW'(i));
      fork
         drive_psums(30);
         begin
            cycles(12);
            start_job(1, 1);
         end
      join
      wait_done(600);
      ready_mode = 0;
      cycles(8);
      check("t5_hs", hs_cnt, 5);
      check("t5_a_cnt", a_cnt, 20);
      check("t5_w_cnt", w_cnt, 5);
      check("t5_idle_busy", busy, 0);
      check("t5_no_extra_done", done_cnt, 1);

      // 6a: k_len=0 behaves as k=1
      clear_stats();
      exp_q = '{8'd9, 8'd6};
      start_job(0, 2);
      psum_q = '{8'd9, 8'd6};
      drive_psums(0);
      wait_done(200);
      check("t6a_a_cnt", a_cnt, 2);
      check("t6a_w_cnt", w_cnt, 2);

      // 6b: n_res=0 -> done with no unit activity
      clear_stats();
      start_job(3, 0);
      wait_done(50);
      check("t6b_acc_act", a_cnt + w_cnt + r_cnt, 0);
      check("t6b_hs", hs_cnt, 0);

      // 6c: reset mid-job, then a fresh job
      clear_stats();
      ready_mode = 1;
      cycles(1);
      start_job(2, 3);
      psum_q = '{8'd1, 8'd2, 8'd3};
      drive_psums(0);
      cycles(4);
      check("t6c_pre_valid", out_valid, 1);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      cycles(2);
      check("t6c_no_done", done_cnt, 0);
      reset_n = 1'b1;
      ready_mode = 0;
      cycles(2);
      check_idle_outputs("postreset");
      clear_stats();
      exp_q = '{8'd30, 8'd70};
      start_job(2, 2);
      psum_q = '{8'd10, 8'd20, 8'd30, 8'd40};
      drive_psums(0);
      wait_done(200);
      check("t6c_hs", hs_cnt, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_accumulator_controller
